// File: rtl/htif_mem_bridge.sv
// Bridges one 128-bit HTIF memory request at a time onto a 32-bit synchronous
// single-port RAM as four beats, gathering read beats into one response pulse.
//
// state      | meaning
// S_IDLE     | ready for a request; latches op/line/data/tag on accept
// S_WRITE    | issuing write beats 0..3
// S_READ     | issuing read beats 0..3, gathering the previous beat
// S_READ_DRAIN | no access; captures beat 3 into the response register
// S_RESP     | one-cycle htif_resp_val pulse
module htif_mem_bridge #(
  parameter int TAG_BITS      = 5,
  parameter int MEM_ADDR_BITS = 14
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     htif_req_val,
  output logic                     htif_req_rdy,
  input  logic                     htif_req_op,
  input  logic [31:0]              htif_req_addr,
  input  logic [127:0]             htif_req_data,
  input  logic [TAG_BITS-1:0]      htif_req_tag,
  output logic                     htif_resp_val,
  output logic [127:0]             htif_resp_data,
  output logic [TAG_BITS-1:0]      htif_resp_tag,
  output logic                     mem_en,
  output logic                     mem_we,
  output logic [MEM_ADDR_BITS-1:0] mem_addr,
  output logic [31:0]              mem_wdata,
  input  logic [31:0]              mem_rdata
);

  localparam int LINE_BITS = MEM_ADDR_BITS - 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_READ_DRAIN,
    S_RESP
  } state_t;

  state_t               state_q, state_d;
  logic                 accept;
  logic [1:0]           beat_q;
  logic [LINE_BITS-1:0] line_q;
  logic [127:0]         wdata_q;
  logic [TAG_BITS-1:0]  tag_q;
  logic [95:0]          gather_q;
  logic [127:0]         resp_data_q;
  logic [TAG_BITS-1:0]  resp_tag_q;

  // Byte-address bits outside the RAM's line range are dropped, so the RAM wraps.
  logic unused_addr;
  assign unused_addr = ^{htif_req_addr[31:MEM_ADDR_BITS+2], htif_req_addr[3:0]};

  assign htif_resp_data = resp_data_q;
  assign htif_resp_tag  = resp_tag_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    accept        = 1'b0;
    htif_req_rdy  = 1'b0;
    htif_resp_val = 1'b0;
    mem_en        = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    case (state_q)
      S_IDLE: begin
        htif_req_rdy = !rst;
        if (htif_req_val && !rst) begin
          accept  = 1'b1;
          state_d = htif_req_op ? S_WRITE : S_READ;
        end
      end
      S_WRITE: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {line_q, beat_q};
        mem_wdata = wdata_q[{beat_q, 5'd0} +: 32];
        if (beat_q == 2'd3) state_d = S_IDLE;
      end
      S_READ: begin
        mem_en   = 1'b1;
        mem_addr = {line_q, beat_q};
        if (beat_q == 2'd3) state_d = S_READ_DRAIN;
      end
      S_READ_DRAIN: state_d = S_RESP;
      S_RESP: begin
        htif_resp_val = 1'b1;
        state_d       = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_q      <= '0;
      line_q      <= '0;
      wdata_q     <= '0;
      tag_q       <= '0;
      gather_q    <= '0;
      resp_data_q <= '0;
      resp_tag_q  <= '0;
    end else begin
      if (accept) begin
        line_q  <= htif_req_addr[MEM_ADDR_BITS+1:4];
        wdata_q <= htif_req_data;
        tag_q   <= htif_req_tag;
        beat_q  <= '0;
      end
      if (state_q == S_WRITE || state_q == S_READ) beat_q <= beat_q + 2'd1;
      // RAM data lags the address by one cycle, so each read cycle stores the prior beat.
      if (state_q == S_READ && beat_q != 2'd0)
        gather_q[{beat_q - 2'd1, 5'd0} +: 32] <= mem_rdata;
      if (state_q == S_READ_DRAIN) begin
        resp_data_q <= {mem_rdata, gather_q};
        resp_tag_q  <= tag_q;
      end
    end
  end

endmodule

// File: tb/tb_htif_mem_bridge.sv
// Directed bench for htif_mem_bridge: behavioural sync RAM plus cycle-exact
// checks of the beat sequence, response pulse, busy hold and reset behaviour.
module tb_htif_mem_bridge;

  localparam int TW = 5;
  localparam int AW = 14;

  logic          clk = 1'b0;
  logic          rst;
  logic          htif_req_val;
  logic          htif_req_rdy;
  logic          htif_req_op;
  logic [31:0]   htif_req_addr;
  logic [127:0]  htif_req_data;
  logic [TW-1:0] htif_req_tag;
  logic          htif_resp_val;
  logic [127:0]  htif_resp_data;
  logic [TW-1:0] htif_resp_tag;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  logic [31:0] ram [0:(1<<AW)-1];

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] D1 = 128'h33333333_22222222_11111111_00000000;
  localparam logic [127:0] D2 = 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF;
  localparam logic [127:0] D3 = 128'hA5A5A5A5_5A5A5A5A_FFFFFFFF_00000001;
  localparam logic [127:0] D4 = 128'h44444444_55555555_66666666_77777777;

  htif_mem_bridge #(.TAG_BITS(TW), .MEM_ADDR_BITS(AW)) dut (
    .clk           (clk),
    .rst           (rst),
    .htif_req_val  (htif_req_val),
    .htif_req_rdy  (htif_req_rdy),
    .htif_req_op   (htif_req_op),
    .htif_req_addr (htif_req_addr),
    .htif_req_data (htif_req_data),
    .htif_req_tag  (htif_req_tag),
    .htif_resp_val (htif_resp_val),
    .htif_resp_data(htif_resp_data),
    .htif_resp_tag (htif_resp_tag),
    .mem_en        (mem_en),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr];
    end
  end

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Called at a negedge in a cycle where rdy is expected; returns at the
  // negedge of the cycle in which rdy is high again.
  task automatic txn(input logic op, input logic [31:0] addr, input logic [127:0] data,
                     input logic [TW-1:0] tag, input logic [AW-1:0] base,
                     input logic [127:0] exp_rd, input logic hold);
    int ncyc;
    htif_req_val  = 1'b1;
    htif_req_op   = op;
    htif_req_addr = addr;
    htif_req_data = data;
    htif_req_tag  = tag;
    check("rdy_before_accept", 128'(htif_req_rdy), 128'(1'b1));
    @(posedge clk);
    ncyc = op ? 5 : 7;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      if (c == 1) begin
        if (!hold) htif_req_val = 1'b0;
        htif_req_op   = ~op;
        htif_req_addr = ~addr;
        htif_req_data = ~data;
        htif_req_tag  = ~tag;
      end
      if (c <= 4) begin
        check("mem_en_beat", 128'(mem_en), 128'(1'b1));
        check("mem_we_beat", 128'(mem_we), 128'(op));
        check("mem_addr_beat", 128'(mem_addr), 128'(AW'(base + AW'(c - 1))));
        if (op) check("mem_wdata_beat", 128'(mem_wdata), 128'(data[32*(c-1) +: 32]));
        check("rdy_busy", 128'(htif_req_rdy), 128'(1'b0));
        check("resp_val_busy", 128'(htif_resp_val), 128'(1'b0));
      end else if (c < ncyc) begin
        check("mem_en_drain", 128'(mem_en), 128'(1'b0));
        check("rdy_busy", 128'(htif_req_rdy), 128'(1'b0));
        check("resp_val", 128'(htif_resp_val), 128'(c == 6));
        if (c == 6) begin
          check("resp_data", htif_resp_data, exp_rd);
          check("resp_tag", 128'(htif_resp_tag), 128'(tag));
        end
      end else begin
        check("rdy_return", 128'(htif_req_rdy), 128'(1'b1));
        check("mem_en_done", 128'(mem_en), 128'(1'b0));
        check("resp_val_done", 128'(htif_resp_val), 128'(1'b0));
        if (!op) begin
          check("resp_data_hold", htif_resp_data, exp_rd);
          check("resp_tag_hold", 128'(htif_resp_tag), 128'(tag));
        end
      end
    end
  endtask

  initial begin
    rst           = 1'b1;
    htif_req_val  = 1'b1;
    htif_req_op   = 1'b1;
    htif_req_addr = 32'h0000_0100;
    htif_req_data = D1;
    htif_req_tag  = 5'd3;

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_rdy", 128'(htif_req_rdy), 128'(1'b0));
      check("rst_mem_en", 128'(mem_en), 128'(1'b0));
      check("rst_mem_we", 128'(mem_we), 128'(1'b0));
      check("rst_mem_addr", 128'(mem_addr), 128'(0));
      check("rst_mem_wdata", 128'(mem_wdata), 128'(0));
      check("rst_resp_val", 128'(htif_resp_val), 128'(1'b0));
      check("rst_resp_data", htif_resp_data, 128'(0));
      check("rst_resp_tag", 128'(htif_resp_tag), 128'(0));
    end
    rst          = 1'b0;
    htif_req_val = 1'b0;
    @(negedge clk);
    check("post_rst_rdy", 128'(htif_req_rdy), 128'(1'b1));
    check("post_rst_no_accept", 128'(mem_en), 128'(1'b0));

    txn(1'b1, 32'h0000_0100, D1, 5'd3,  14'h0040, '0, 1'b0);
    txn(1'b0, 32'h0000_0100, '0, 5'd7,  14'h0040, D1, 1'b0);
    txn(1'b0, 32'h0001_010C, '0, 5'd31, 14'h0040, D1, 1'b0);

    txn(1'b1, 32'h0000_0200, D2, 5'd1,  14'h0080, '0, 1'b1);
    txn(1'b0, 32'h0000_0200, '0, 5'd2,  14'h0080, D2, 1'b1);
    txn(1'b1, 32'h0000_0300, D3, 5'd4,  14'h00C0, '0, 1'b1);
    txn(1'b0, 32'h0000_0300, '0, 5'd5,  14'h00C0, D3, 1'b0);

    htif_req_val  = 1'b1;
    htif_req_op   = 1'b0;
    htif_req_addr = 32'h0000_0200;
    htif_req_tag  = 5'd9;
    @(posedge clk);
    @(negedge clk);
    htif_req_val = 1'b0;
    check("mr_en_c1", 128'(mem_en), 128'(1'b1));
    @(negedge clk);
    check("mr_en_c2", 128'(mem_en), 128'(1'b1));
    @(negedge clk);
    check("mr_en_c3", 128'(mem_en), 128'(1'b1));
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int c = 4; c <= 8; c++) begin
      @(negedge clk);
      check("mr_en_after", 128'(mem_en), 128'(1'b0));
      check("mr_no_resp", 128'(htif_resp_val), 128'(1'b0));
      check("mr_rdy", 128'(htif_req_rdy), 128'(1'b1));
    end
    check("mr_resp_data_cleared", htif_resp_data, 128'(0));

    txn(1'b0, 32'h0000_0200, '0, 5'd10, 14'h0080, D2, 1'b0);
    txn(1'b1, 32'h0000_FFF0, D4, 5'd11, 14'h3FFC, '0, 1'b0);
    txn(1'b0, 32'h0000_FFF0, '0, 5'd12, 14'h3FFC, D4, 1'b0);
    txn(1'b0, 32'h0000_0100, '0, 5'd13, 14'h0040, D1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
